// File: rtl/out_port_serializer_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// out_port_serializer_pkg
// Shared definitions for the CPU output-port serializer:
//   - 2-bit encoding of the serializer FSM states
//   - 8N1 frame geometry (start bit, eight data bits, stop bit)
// No ports; imported by out_port_serializer.
// ---------------------------------------------------------------------------
package out_port_serializer_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_STOP  = ST_STOP_ENC
  } ser_state_e;

  // Bits per 8N1 frame: one start, eight data, one stop.
  localparam int unsigned FRAME_BITS = 10;

  // Index of the last data bit inside the DATA state (start and stop excluded).
  localparam int unsigned LAST_DATA_IDX = FRAME_BITS - 3;

endpackage

// File: rtl/out_port_serializer_sync_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and full flag.
//   clk, reset_n  : clock and asynchronous active-low reset
//   push, wdata   : write request and data; ignored while full
//   pop, rdata    : read request; rdata always shows the head entry
//   count         : occupancy after the most recent edge
//   full, empty   : occupancy == DEPTH / occupancy == 0
// A push while full is dropped even if a pop happens on the same edge, so the
// caller can rely on "full before the edge" to detect a lost byte.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the registered occupancy; DEPTH is a power of
  // two so the pointers wrap naturally at their width.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/out_port_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// out_port_serializer
// Captures bytes the CPU writes via doOut/dbus, buffers them in a small FIFO
// and shifts them out on tx as 8N1 frames, LSB first.
//   clk, reset_n : clock and asynchronous active-low reset
//   doOut, dbus  : output strobe and data byte, sampled on posedge
//   tx           : registered serial line, idle high
//   busy         : a frame is in START, DATA or STOP
//   full, count  : FIFO full flag and occupancy (registered)
//   overflow     : sticky, set when a byte is dropped because the FIFO is full
// ---------------------------------------------------------------------------
module out_port_serializer
  import out_port_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   doOut,
  input  logic [7:0]             dbus,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(LAST_DATA_IDX);

  ser_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic                   bit_end;
  logic                   fifo_pop;
  logic [7:0]             fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (doOut),
    .pop     (fifo_pop),
    .wdata   (dbus),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  // Frame sequencer. A pop happens only when leaving IDLE or when a STOP bit
  // ends with data waiting, which chains frames with no idle gap. The baud
  // counter is cleared on every state change so each bit lasts exactly
  // CLKS_PER_BIT cycles.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // tx is computed from the next state so the line register changes on the
  // same edge as the state, keeping tx free of any path from the inputs.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // The FIFO's full flag is the occupancy before this edge, which is exactly
  // when a strobed byte is lost, regardless of a simultaneous pop.
  always_comb begin
    overflow_d = overflow_q | (doOut & fifo_full);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign full     = fifo_full;
  assign count    = fifo_count;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_out_port_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_out_port_serializer
// Directed bench for out_port_serializer with a frame-level reference model
// (byte queue plus position inside the current 40-cycle frame), a line
// receiver that decodes tx back into bytes, and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_out_port_serializer;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       reset_n;
  logic       doOut;
  logic [7:0] dbus;
  logic       tx;
  logic       busy;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int checkCount = 0;
  int failCount  = 0;
  int framingErrors = 0;
  int resetCount = 0;

  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  // Reference model state
  logic [7:0] mq[$];
  logic       mActive;
  int         mT;
  logic [7:0] mByte;
  logic       mOverflow;

  out_port_serializer #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .doOut    (doOut),
    .dbus     (dbus),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Line level of an 8N1 frame t cycles after its start bit began.
  function automatic logic frameBit(input logic [7:0] b, input int t);
    int idx;
    idx = t / CPB;
    if (idx == 0) return 1'b0;
    else if (idx >= 9) return 1'b1;
    else return b[idx-1];
  endfunction

  task automatic modelReset();
    mq.delete();
    mActive   = 1'b0;
    mT        = 0;
    mByte     = 8'h00;
    mOverflow = 1'b0;
  endtask

  // One clock edge: the head byte starts a frame when the line is free or the
  // current frame is on its final cycle; the strobed byte is lost if the queue
  // was already full before the edge.
  task automatic modelStep();
    int         n;
    logic       doPop;
    logic [7:0] popped;
    n      = mq.size();
    doPop  = (n > 0) && (!mActive || mT == FRAME_CYC - 1);
    popped = 8'h00;
    if (doPop) popped = mq.pop_front();
    if (doOut === 1'b1) begin
      if (n == DEPTH) mOverflow = 1'b1;
      else mq.push_back(dbus);
    end
    if (doPop) begin
      mActive = 1'b1;
      mT      = 0;
      mByte   = popped;
    end else if (mActive) begin
      if (mT == FRAME_CYC - 1) mActive = 1'b0;
      else mT++;
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) modelReset();
      else modelStep();
    end
  end

  // Compare process: every negedge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_tx", tx, mActive ? frameBit(mByte, mT) : 1'b1);
      checkOutput("model_busy", busy, mActive);
      checkOutput("model_count", count, mq.size());
      checkOutput("model_full", full, (mq.size() == DEPTH));
      checkOutput("model_overflow", overflow, mOverflow);
    end
  end

  initial begin
    forever begin
      @(negedge reset_n);
      resetCount++;
    end
  end

  // Line receiver: detects a start bit and samples each following bit one
  // bit-time apart; frames cut by a reset are discarded.
  initial begin
    forever begin : receiver
      logic [7:0] rxData;
      logic       stopBit;
      int         rstMark;
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        rstMark = resetCount;
        rxData  = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rxData[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopBit = tx;
        if (rstMark == resetCount) begin
          rxQ.push_back(rxData);
          if (stopBit !== 1'b1) framingErrors++;
        end
      end
    end
  end

  // Drives one strobed byte; called at a negedge, returns at the next one.
  task automatic applyStimulus(input logic [7:0] b);
    doOut = 1'b1;
    dbus  = b;
    @(negedge clk);
    doOut = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int   n;
    logic timedOut;
    n = 0;
    while ((busy || count != 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    timedOut = (busy || count != 3'd0);
    checkOutput({tag, "_idle_wait"}, timedOut, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkRx(input string tag);
    checkOutput({tag, "_rx_len"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput($sformatf("%s_rx_byte%0d", tag, i), rxQ[i], expQ[i]);
    end
    rxQ.delete();
    expQ.delete();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rxQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    doOut   = 1'b0;
    dbus    = 8'h00;

    // Test 1: reset values while held and after release
    repeat (2) @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_tx", tx, 1'b1);
    checkOutput("rel_busy", busy, 1'b0);

    // Test 2: single 0x55 frame, latency and duration
    applyStimulus(8'h55);
    checkOutput("t2_tx_after_push", tx, 1'b1);
    checkOutput("t2_count_after_push", count, 3'd1);
    @(negedge clk);
    checkOutput("t2_tx_start", tx, 1'b0);
    checkOutput("t2_busy_start", busy, 1'b1);
    checkOutput("t2_count_after_pop", count, 3'd0);
    repeat (39) @(negedge clk);
    checkOutput("t2_busy_last_cycle", busy, 1'b1);
    @(negedge clk);
    checkOutput("t2_busy_done", busy, 1'b0);
    checkOutput("t2_tx_done", tx, 1'b1);
    expQ.push_back(8'h55);
    checkRx("t2");

    // Test 3: back-to-back 0xA3, 0x0F
    applyStimulus(8'hA3);
    applyStimulus(8'h0F);
    checkOutput("t3_count_peak", count, 3'd1);
    waitIdle(300, "t3");
    expQ.push_back(8'hA3);
    expQ.push_back(8'h0F);
    checkRx("t3");

    // Test 4: six writes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    checkOutput("t4_full", full, 1'b1);
    checkOutput("t4_count_full", count, 3'd4);
    checkOutput("t4_overflow_before", overflow, 1'b0);
    applyStimulus(8'h06);
    checkOutput("t4_overflow_set", overflow, 1'b1);
    checkOutput("t4_count_after_drop", count, 3'd4);
    waitIdle(600, "t4");
    for (int i = 1; i <= 5; i++) expQ.push_back(8'(i));
    checkRx("t4");
    checkOutput("t4_overflow_sticky", overflow, 1'b1);

    // Test 5a: strobe on the STOP->START pop edge while full -> dropped
    pulseReset();
    checkOutput("t5a_overflow_cleared", overflow, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    repeat (36) @(negedge clk);
    checkOutput("t5a_count_before", count, 3'd4);
    checkOutput("t5a_busy_before", busy, 1'b1);
    applyStimulus(8'h99);
    checkOutput("t5a_overflow", overflow, 1'b1);
    checkOutput("t5a_count_after", count, 3'd3);
    waitIdle(600, "t5a");
    for (int i = 0; i < 5; i++) expQ.push_back(8'h10 + 8'(i));
    checkRx("t5a");

    // Test 5b: same edge with one free slot -> accepted, count unchanged
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h20 + 8'(i));
    repeat (37) @(negedge clk);
    checkOutput("t5b_count_before", count, 3'd3);
    applyStimulus(8'h24);
    checkOutput("t5b_count_after", count, 3'd3);
    checkOutput("t5b_overflow", overflow, 1'b0);
    waitIdle(600, "t5b");
    for (int i = 0; i < 5; i++) expQ.push_back(8'h20 + 8'(i));
    checkRx("t5b");

    // Test 6: asynchronous reset during DATA bit 3 of 0x00
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    repeat (17) @(negedge clk);
    checkOutput("t6_tx_bit3", tx, 1'b0);
    checkOutput("t6_count_before", count, 3'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_tx", tx, 1'b1);
    checkOutput("t6_async_count", count, 3'd0);
    checkOutput("t6_async_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    rxQ.delete();
    applyStimulus(8'hFF);
    waitIdle(300, "t6");
    expQ.push_back(8'hFF);
    checkRx("t6");
    checkOutput("t6_tx_idle", tx, 1'b1);

    checkOutput("framing_errors", framingErrors, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/out_port_serializer.md
Name: out_port_serializer

Overview:
- Consumer at the far end of the CPU output path. It captures each byte the CPU writes through the doOut control bit, queues it in a small FIFO, and shifts it out on a single wire as 8N1 frames.
- It sits beside the register file, sampling the same dbus and doOut, and feeds the simulator's serial console or a board pin.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per serial bit; must be >= 2.
- DEPTH, 4: FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- doOut  input  1  output-strobe control bit; a byte is offered on a posedge where it is high.
- dbus  input  8  data bus; sampled when doOut is high.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in START, DATA or STOP.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a byte is dropped.

Behaviour:
- Reset:
  - reset_n low forces the following immediately, without waiting for clk: tx=1, busy=0, full=0, count=0, overflow=0, FSM=IDLE, FIFO pointers=0, bit and baud counters=0.
  - Reset asserted mid-frame aborts the frame; tx goes high at once.
  - FIFO contents are discarded.
- Push:
  - On a posedge with doOut=1 and count<DEPTH (value before the edge), dbus is written at the write pointer, the write pointer increments and wraps mod DEPTH, and count increments.
  - If count==DEPTH before the edge, the byte is dropped and overflow is set. This holds even if a pop happens on the same edge.
  - overflow clears only on reset.
- Pop:
  - Happens only on an edge where the FSM leaves IDLE, or leaves STOP with the FIFO non-empty.
  - The head byte loads into an 8-bit shift register, the read pointer increments and wraps, and count decrements.
  - A push and a pop on the same edge leave count unchanged.
- FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1 in each non-IDLE state; "bit end" means the counter equals CLKS_PER_BIT-1.
  - IDLE: tx=1, busy=0. If count>0, pop and go to START, with the baud counter set to 0.
  - START: tx=0. At bit end go to DATA, with the bit index set to 0.
  - DATA: tx = shift[0], sent LSB first. At bit end, shift right. If bit index==7 go to STOP, otherwise increment the bit index.
  - STOP: tx=1. At bit end:
    - if count>0, pop and go straight to START (no idle gap);
    - otherwise go to IDLE.
- tx is driven from a register, so there is no combinational path from the inputs to tx.
- Latency:
  - A byte pushed into an empty FIFO while IDLE at edge N is popped at edge N+1; tx falls after edge N+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- full and count are registered and reflect the state after the most recent edge.

Decomposition:
- Shared package (existing project defines file): the FSM state encoding (2-bit localparams) and the 8N1 frame length constant (10).
- One natural sub-module: sync_fifo (parameters WIDTH=8 and DEPTH).
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clk and reset_n.
  - Rejects a push when full, and handles simultaneous push and pop.
- The serializer FSM lives in the top module.

Test Plan:
1. Reset with reset_n=0 for 3 cycles, then release -> tx=1, busy=0, count=0, full=0, overflow=0.
2. CLKS_PER_BIT=4: one doOut with dbus=0x55 while idle -> tx falls 1 cycle after the push edge. The tx bit sequence is 0,1,0,1,0,1,0,1,0,1, each bit lasting 4 cycles; then tx stays high and busy drops after 40 cycles.
3. Back-to-back writes of 0xA3, 0x0F on consecutive cycles -> two frames with no idle cycle between them. The data bits are 1,1,0,0,0,1,0,1, then 1,1,1,1,0,0,0,0. count peaks at 1.
4. Six consecutive writes 0x01..0x06 with DEPTH=4:
   - 0x01 is popped into the shift register on the second edge; 0x02..0x05 fill the FIFO, so full=1.
   - 0x06 is dropped and overflow=1.
   - Serial output is exactly 0x01..0x05, and overflow stays 1 afterwards.
5. doOut on the same edge as the STOP-to-START pop with count==DEPTH -> the byte is dropped and overflow is set. With count==DEPTH-1 instead -> the byte is accepted and count is unchanged.
6. reset_n pulsed low during DATA bit 3 of 0x00 -> tx=1 immediately (asynchronously) and count=0. After release, a new write of 0xFF transmits a correct, complete frame.
